// File: rtl/dotp_pkg.sv
// Shared types and defaults for the streaming int8 dot-product engine.
package dotp_pkg;
  localparam int DOTP_LANES = 8;
  localparam int DOTP_DW    = 8;
  localparam int DOTP_ACCW  = 32;
  localparam int DOTP_LENW  = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_REDUCE = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  // ceil(n / 2**lg), without widening n past the length field.
  function automatic logic [DOTP_LENW-1:0] beat_count(input logic [DOTP_LENW-1:0] n,
                                                      input int unsigned lg);
    logic [DOTP_LENW-1:0] tail;
    tail = DOTP_LENW'((32'd1 << lg) - 32'd1);
    return (n >> lg) + {{(DOTP_LENW-1){1'b0}}, |(n & tail)};
  endfunction
endpackage

// File: rtl/dotp_stream_if.sv
// Job control, operand stream and result handshake of dotp_stream.
interface dotp_stream_if import dotp_pkg::*; #(
  parameter int LANES = DOTP_LANES,
  parameter int DW    = DOTP_DW,
  parameter int ACCW  = DOTP_ACCW,
  parameter int LENW  = DOTP_LENW
);
  logic                   start;
  logic [LENW-1:0]        len;
  logic signed [DW:0]     a_zp;
  logic signed [DW:0]     b_zp;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*DW-1:0]    in_a;
  logic [LANES*DW-1:0]    in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACCW-1:0]        out_data;
  logic                   busy;

  modport master (
    output start, len, a_zp, b_zp, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, len, a_zp, b_zp, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/dotp_lane_mac.sv
// One lane: zero-point subtract, signed multiply and wrapping accumulator.
module dotp_lane_mac import dotp_pkg::*; #(
  parameter int DW   = DOTP_DW,
  parameter int ACCW = DOTP_ACCW
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   mask,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  input  logic signed [DW:0]     a_zp,
  input  logic signed [DW:0]     b_zp,
  output logic signed [ACCW-1:0] acc
);
  localparam int PW = 2*DW + 2;

  logic signed [DW:0]   da;
  logic signed [DW:0]   db;
  logic signed [PW-1:0] prod;

  assign da   = {a[DW-1], a} - a_zp;
  assign db   = {b[DW-1], b} - b_zp;
  assign prod = da * db;

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      acc <= '0;
    end else if (en && !mask) begin
      acc <= acc + {{(ACCW-PW){prod[PW-1]}}, prod};
    end
  end
endmodule

// File: rtl/dotp_stream.sv
// Streaming int8 dot product: runtime length, LANES-wide beats, zero points, tail masking.
//   state    | meaning
//   S_IDLE   | accumulators and beat counter cleared, waiting for start
//   S_LOAD   | in_ready high, accumulating beats until the last one
//   S_REDUCE | one cycle, lane accumulators summed into out_data
//   S_OUT    | out_valid high, result held until out_ready
module dotp_stream import dotp_pkg::*; #(
  parameter int LANES = DOTP_LANES,
  parameter int DW    = DOTP_DW,
  parameter int ACCW  = DOTP_ACCW,
  parameter int LENW  = DOTP_LENW
) (
  input  logic         clk,
  input  logic         resetn,
  dotp_stream_if.slave bus
);
  localparam int LG = $clog2(LANES);

  state_t                 state, state_nx;
  logic [LENW-1:0]        cnt;
  logic [LENW-1:0]        beats_r;
  logic [LG-1:0]          rem_r;
  logic signed [DW:0]     azp_r;
  logic signed [DW:0]     bzp_r;
  logic                   clr;
  logic                   fire;
  logic                   last_beat;
  logic [LANES-1:0]       mask;
  logic signed [ACCW-1:0] acc [LANES];
  logic signed [ACCW-1:0] sum;
  logic [ACCW-1:0]        out_q;

  assign last_beat = (cnt == beats_r - LENW'(1));

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    fire     = 1'b0;
    case (state)
      S_IDLE: begin
        clr = 1'b1;
        if (bus.start) state_nx = (bus.len != '0) ? S_LOAD : S_REDUCE;
      end
      S_LOAD: begin
        fire = bus.in_valid;
        if (fire && last_beat) state_nx = S_REDUCE;
      end
      S_REDUCE: state_nx = S_OUT;
      S_OUT:    if (bus.out_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      beats_r <= '0;
      rem_r   <= '0;
      azp_r   <= '0;
      bzp_r   <= '0;
      out_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE) begin
        cnt <= '0;
        if (bus.start) begin
          beats_r <= beat_count(bus.len, LG);
          rem_r   <= bus.len[LG-1:0];
          azp_r   <= bus.a_zp;
          bzp_r   <= bus.b_zp;
        end
      end
      if (fire) cnt <= cnt + LENW'(1);
      if (state == S_REDUCE) out_q <= sum;
    end
  end

  // On the last beat only lanes below len mod LANES are live; rem 0 means a full beat.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign mask[i] = last_beat && (rem_r != '0) && (LG'(i) >= rem_r);

    dotp_lane_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
      .clk    (clk),
      .resetn (resetn),
      .clr    (clr),
      .en     (fire),
      .mask   (mask[i]),
      .a      (bus.in_a[i*DW +: DW]),
      .b      (bus.in_b[i*DW +: DW]),
      .a_zp   (azp_r),
      .b_zp   (bzp_r),
      .acc    (acc[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) sum = sum + acc[i];
  end

  assign bus.in_ready  = (state == S_LOAD);
  assign bus.out_valid = (state == S_OUT);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_data  = out_q;
endmodule

// File: tb/tb_dotp_stream.sv
// Self-checking bench for dotp_stream with an arithmetic reference model.
module tb_dotp_stream;
  logic clk;
  logic resetn;

  dotp_stream_if bus ();

  dotp_stream dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int va[$];
  int vb[$];
  logic [31:0] got;
  int lat;
  bit saw_ready;
  logic post_ready;

  function automatic int wrap9(input int x);
    logic signed [8:0] t;
    t = x[8:0];
    return int'(t);
  endfunction

  function automatic logic [31:0] ref_dot(input int len, input int azp, input int bzp);
    int s;
    s = 0;
    for (int k = 0; k < len; k++) s += wrap9(va[k] - azp) * wrap9(vb[k] - bzp);
    return 32'(s);
  endfunction

  // Runs one job with the operands in va/vb; leaves the result in got, out_ready low.
  task automatic run_job(input int len, input int azp, input int bzp, input int gap_pct,
                         input bit junk7f);
    int nb, beat, cyc;
    bit v;
    logic [63:0] ta, tb2;
    nb = (len + 7) / 8;
    saw_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 16'(len);
    bus.a_zp  = 9'(azp);
    bus.b_zp  = 9'(bzp);
    @(negedge clk);
    bus.start = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat < nb && cyc < 2000) begin
      for (int j = 0; j < 8; j++) begin
        if (beat*8 + j < len) begin
          ta[j*8 +: 8]  = 8'(va[beat*8 + j]);
          tb2[j*8 +: 8] = 8'(vb[beat*8 + j]);
        end else if (junk7f) begin
          ta[j*8 +: 8]  = 8'h7F;
          tb2[j*8 +: 8] = 8'h7F;
        end else begin
          ta[j*8 +: 8]  = 8'($urandom);
          tb2[j*8 +: 8] = 8'($urandom);
        end
      end
      bus.in_a = ta;
      bus.in_b = tb2;
      v = ($urandom_range(99) >= gap_pct);
      bus.in_valid = v;
      if (bus.in_ready) saw_ready = 1'b1;
      if (v && bus.in_ready) beat++;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (cyc >= 2000) begin
      checks++; errors++;
      $display("FAIL beat_timeout: accepted %0d beats, required %0d", beat, nb);
    end
    post_ready = bus.in_ready;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) saw_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, lat);
    end
    got = bus.out_data;
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic fill_ramp(input int len);
    va.delete(); vb.delete();
    for (int k = 0; k < len; k++) begin va.push_back(k + 1); vb.push_back(k + 1); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready: got %b, required 0", bus.in_ready); end
    if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    if (bus.out_data !== 32'd0)  begin errors++; $display("FAIL reset_out_data: got %0d, required 0", bus.out_data); end
    if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    fill_ramp(70);
    run_job(70, 0, 0, 0, 1'b0);
    checks += 5;
    if (got !== 32'd116795)     begin errors++; $display("FAIL basic_len70: got %0d, required 116795", got); end
    if (got !== ref_dot(70, 0, 0)) begin errors++; $display("FAIL basic_model: got %0d, required %0d", got, ref_dot(70, 0, 0)); end
    if (post_ready !== 1'b0)    begin errors++; $display("FAIL basic_ready_drop: in_ready=%b after last beat, required 0", post_ready); end
    if (lat !== 1)              begin errors++; $display("FAIL basic_latency: got %0d, required 1", lat); end
    if (bus.busy !== 1'b1)      begin errors++; $display("FAIL basic_busy_out: got %b, required 1", bus.busy); end
    take_result();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_taken_valid: got %b, required 0", bus.out_valid); end
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL basic_taken_busy: got %b, required 0", bus.busy); end
  endtask

  task automatic test_zero_point();
    fill_ramp(8);
    run_job(8, 1, 0, 0, 1'b0);
    checks++;
    if (got !== 32'd168) begin errors++; $display("FAIL zp_a1: got %0d, required 168", got); end
    take_result();
  endtask

  task automatic test_extremes();
    logic [31:0] exp_neg;
    va.delete(); vb.delete();
    for (int k = 0; k < 8; k++) begin va.push_back(-128); vb.push_back(-128); end
    run_job(8, 0, 0, 0, 1'b0);
    checks++;
    if (got !== 32'd131072) begin errors++; $display("FAIL ext_min_min: got %0d, required 131072", got); end
    take_result();
    vb.delete();
    for (int k = 0; k < 8; k++) vb.push_back(127);
    exp_neg = 32'(-130048);
    run_job(8, 0, 0, 0, 1'b0);
    checks++;
    if (got !== exp_neg) begin errors++; $display("FAIL ext_min_max: got %0d, required %0d", $signed(got), $signed(exp_neg)); end
    take_result();
  endtask

  task automatic test_tail();
    fill_ramp(3);
    run_job(3, 0, 0, 0, 1'b1);
    checks++;
    if (got !== 32'd14) begin errors++; $display("FAIL tail_len3: got %0d, required 14", got); end
    take_result();
    va.delete(); vb.delete();
    run_job(0, 0, 0, 0, 1'b1);
    checks += 3;
    if (got !== 32'd0)      begin errors++; $display("FAIL len0_data: got %0d, required 0", got); end
    if (saw_ready !== 1'b0) begin errors++; $display("FAIL len0_ready: in_ready pulse seen=%b, required 0", saw_ready); end
    if (lat !== 1)          begin errors++; $display("FAIL len0_latency: got %0d, required 1", lat); end
    take_result();
  endtask

  task automatic random_job(input int gap_pct);
    int len, azp, bzp;
    len = $urandom_range(40, 1);
    azp = $urandom_range(16) - 8;
    bzp = $urandom_range(16) - 8;
    va.delete(); vb.delete();
    for (int k = 0; k < len; k++) begin
      va.push_back($urandom_range(255) - 128);
      vb.push_back($urandom_range(255) - 128);
    end
    run_job(len, azp, bzp, gap_pct, 1'b0);
    checks++;
    if (got !== ref_dot(len, azp, bzp))
      begin errors++; $display("FAIL rand_len%0d: got %0d, required %0d", len, $signed(got), $signed(ref_dot(len, azp, bzp))); end
  endtask

  task automatic test_gaps_hold();
    logic [31:0] held;
    for (int n = 0; n < 4; n++) begin
      random_job(50);
      take_result();
    end
    random_job(40);
    held = got;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin bus.start = 1'b1; bus.len = 16'd5; end
      if (i == 3) bus.start = 1'b0;
      @(negedge clk);
      checks += 2;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_%0d: got %b, required 1", i, bus.out_valid); end
      if (bus.out_data !== held)  begin errors++; $display("FAIL hold_data_%0d: got %0d, required %0d", i, bus.out_data, held); end
    end
    take_result();
    @(negedge clk);
    checks += 2;
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL hold_no_new_job: busy=%b, required 0", bus.busy); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_released: out_valid=%b, required 0", bus.out_valid); end
    random_job(20);
    take_result();
  endtask

  task automatic test_reset_midjob();
    fill_ramp(70);
    @(negedge clk);
    bus.start = 1'b1; bus.len = 16'd70; bus.a_zp = 9'd0; bus.b_zp = 9'd0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int bt = 0; bt < 3; bt++) begin
      bus.in_a = 64'h0102030405060708;
      bus.in_b = 64'h0102030405060708;
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_load: in_ready=%b, required 1", bus.in_ready); end
    bus.in_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL mid_reset_ready: got %b, required 0", bus.in_ready); end
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL mid_reset_busy: got %b, required 0", bus.busy); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b, required 0", bus.out_valid); end
    resetn = 1'b1;
    @(negedge clk);
    run_job(70, 0, 0, 30, 1'b0);
    checks++;
    if (got !== 32'd116795) begin errors++; $display("FAIL mid_rerun: got %0d, required 116795", got); end
    take_result();
  endtask

  initial begin
    resetn        = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.a_zp      = '0;
    bus.b_zp      = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero_point();
    test_extremes();
    test_tail();
    test_gaps_hold();
    test_reset_midjob();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
